// File: rtl/circle_angle_sequencer.sv
`default_nettype none
// circle_angle_sequencer: feeds a CORDIC with the base-2 van der Corput angle
// sequence and streams each cosine/sine result out as a unit-circle point.
module circle_angle_sequencer #(
    parameter int ANGLE_W = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               seed_load,
    input  logic [ANGLE_W-1:0] seed,
    output logic               cordic_start,
    output logic [ANGLE_W-1:0] cordic_angle,
    input  logic               cordic_ready,
    input  logic               cordic_done,
    input  logic [DATA_W-1:0]  cordic_cosine,
    input  logic [DATA_W-1:0]  cordic_sine,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [DATA_W-1:0]  pt_x,
    output logic [DATA_W-1:0]  pt_y,
    output logic [ANGLE_W-1:0] pt_index,
    output logic               busy,
    output logic               err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]         state;
    logic [ANGLE_W-1:0] k;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ANGLE_W-1:0] idx_next;
    logic [ANGLE_W-1:0] idx_after;

    function automatic logic [ANGLE_W-1:0] bitrev(input logic [ANGLE_W-1:0] v);
        logic [ANGLE_W-1:0] r;
        for (int i = 0; i < ANGLE_W; i++) begin
            r[i] = v[ANGLE_W-1-i];
        end
        return r;
    endfunction

    // k is the last emitted index; idx_after is needed when accepting a point
    // and immediately loading the angle for the one after it.
    assign idx_next     = k + ANGLE_W'(1);
    assign idx_after    = k + ANGLE_W'(2);
    assign cordic_start = (state == ST_ISSUE) && cordic_ready;
    assign pt_valid     = (state == ST_HOLD);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            k            <= '0;
            wait_cnt     <= '0;
            cordic_angle <= '0;
            pt_x         <= '0;
            pt_y         <= '0;
            pt_index     <= '0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (seed_load) begin
                        k           <= seed;
                        err_timeout <= 1'b0;
                    end else if (run) begin
                        cordic_angle <= bitrev(idx_next);
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cordic_ready) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end else if (!run) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cordic_done) begin
                        pt_x     <= cordic_cosine;
                        pt_y     <= cordic_sine;
                        pt_index <= idx_next;
                        state    <= ST_HOLD;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Abort leaves k untouched so the same index is retried.
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (pt_ready) begin
                        k <= idx_next;
                        if (run) begin
                            cordic_angle <= bitrev(idx_after);
                            state        <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
